// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 keyboard frame receiver with E0/F0 prefix decoding and per-key
// held/pulse/LED outputs for a programmable table of scan codes.  Rev 1.0
`default_nettype none

module ps2_key_decoder #(
  parameter int                    CLK_DIV       = 250,
  parameter int                    TIMEOUT_TICKS = 4000,
  parameter int                    NUM_KEYS      = 2,
  parameter logic [NUM_KEYS*9-1:0] KEY_CODES     = {9'h174, 9'h16B},
  parameter int                    LED_HOLD      = 10_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ps2_clk,
  input  logic                ps2_data,
  output logic                byte_valid,
  output logic [7:0]          byte_data,
  output logic                frame_err,
  output logic [NUM_KEYS-1:0] key_down,
  output logic [NUM_KEYS-1:0] key_pulse,
  output logic [NUM_KEYS-1:0] key_led
);

  localparam int c_DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int c_TO_W  = $clog2(TIMEOUT_TICKS + 1);
  localparam int c_LED_W = $clog2(LED_HOLD + 1);

  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
  localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(TIMEOUT_TICKS - 1);
  localparam logic [c_LED_W-1:0] c_LED_LOAD = c_LED_W'(LED_HOLD);

  localparam logic [7:0] c_PFX_EXT = 8'hE0;
  localparam logic [7:0] c_PFX_BRK = 8'hF0;

  logic [1:0] r_clk_sync;
  logic [1:0] r_dat_sync;
  logic       w_clk_s;
  logic       w_dat_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
    end else begin
      r_clk_sync <= {r_clk_sync[0], ps2_clk};
      r_dat_sync <= {r_dat_sync[0], ps2_data};
    end
  end

  assign w_clk_s = r_clk_sync[1];
  assign w_dat_s = r_dat_sync[1];

  logic [c_DIV_W-1:0] r_div;
  logic               r_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else if (r_div == c_DIV_LAST) begin
      r_div  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_div  <= r_div + 1'b1;
      r_tick <= 1'b0;
    end
  end

  logic              r_clk_prev;
  logic [10:0]       r_shift;
  logic [3:0]        r_cnt;
  logic [c_TO_W-1:0] r_to;
  logic              r_byte_valid;
  logic              r_frame_err;
  logic [7:0]        r_byte;
  logic              w_fall;

  assign w_fall = r_tick & r_clk_prev & ~w_clk_s;

  // r_shift fills from the top, so once 11 bits are in: [0]=start, [8:1]=data, [9]=parity, [10]=stop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_prev   <= 1'b1;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_to         <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_byte       <= '0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      if (r_tick) r_clk_prev <= w_clk_s;
      if (r_cnt == 4'd11) begin
        r_cnt <= '0;
        r_to  <= '0;
        if (!r_shift[0] && r_shift[10] && (^r_shift[9:1])) begin
          r_byte       <= r_shift[8:1];
          r_byte_valid <= 1'b1;
        end else begin
          r_frame_err <= 1'b1;
        end
      end else if (w_fall) begin
        r_shift <= {w_dat_s, r_shift[10:1]};
        r_cnt   <= r_cnt + 4'd1;
        r_to    <= '0;
      end else if (r_tick && (r_cnt != 4'd0)) begin
        if (r_to == c_TO_LAST) begin
          r_cnt <= '0;
          r_to  <= '0;
        end else begin
          r_to <= r_to + 1'b1;
        end
      end
    end
  end

  logic [NUM_KEYS-1:0] w_hit_std;
  logic [NUM_KEYS-1:0] w_hit_ext;

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_match
    assign w_hit_std[gi] = (KEY_CODES[9*gi +: 9] == {1'b0, r_byte});
    assign w_hit_ext[gi] = (KEY_CODES[9*gi +: 9] == {1'b1, r_byte});
  end

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  state_t              r_state;
  logic [NUM_KEYS-1:0] r_down;
  logic [NUM_KEYS-1:0] r_pulse;

  // A bad frame drops any pending prefix so the next byte is read as a fresh code
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_down  <= '0;
      r_pulse <= '0;
    end else begin
      r_pulse <= '0;
      if (r_frame_err) begin
        r_state <= S_IDLE;
      end else if (r_byte_valid) begin
        case (r_state)
          S_IDLE: begin
            if (r_byte == c_PFX_EXT) begin
              r_state <= S_EXT;
            end else if (r_byte == c_PFX_BRK) begin
              r_state <= S_BRK;
            end else begin
              r_pulse <= w_hit_std & ~r_down;
              r_down  <= r_down | w_hit_std;
            end
          end
          S_EXT: begin
            if (r_byte == c_PFX_BRK) begin
              r_state <= S_EXT_BRK;
            end else begin
              r_pulse <= w_hit_ext & ~r_down;
              r_down  <= r_down | w_hit_ext;
              r_state <= S_IDLE;
            end
          end
          S_BRK: begin
            r_down  <= r_down & ~w_hit_std;
            r_state <= S_IDLE;
          end
          S_EXT_BRK: begin
            r_down  <= r_down & ~w_hit_ext;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  logic [NUM_KEYS-1:0] r_led;

  for (genvar gk = 0; gk < NUM_KEYS; gk++) begin : g_led
    logic [c_LED_W-1:0] r_led_cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_led_cnt  <= '0;
        r_led[gk]  <= 1'b0;
      end else if (r_pulse[gk]) begin
        r_led_cnt  <= c_LED_LOAD;
        r_led[gk]  <= 1'b1;
      end else if (r_led_cnt > 1) begin
        r_led_cnt  <= r_led_cnt - 1'b1;
      end else if (r_led_cnt == 1) begin
        r_led_cnt  <= '0;
        r_led[gk]  <= 1'b0;
      end
    end
  end

  assign byte_valid = r_byte_valid;
  assign byte_data  = r_byte;
  assign frame_err  = r_frame_err;
  assign key_down   = r_down;
  assign key_pulse  = r_pulse;
  assign key_led    = r_led;

endmodule

`default_nettype wire
